adc_spi_capture: RTL and testbench

// - Parametrised serial ADC front-end. Drives chip-select and serial clock and

---
 rtl/adc_spi_capture_pkg.sv | 24 ++
 rtl/adc_spi_capture_sclk_gen.sv | 41 ++++
 rtl/adc_spi_capture.sv | 116 +++++++++++
 tb/tb_adc_spi_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_capture_pkg.sv
// Shared types and defaults for the serial ADC capture front-end.
// Defaults match the equaliser top so both sides agree on frame geometry.
package adc_spi_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_LOAD     = 3'd3,
        ST_GAP      = 3'd4
    } adc_state_e;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_DATA_W     = 12;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_CS_IDLE    = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_spi_capture_sclk_gen.sv
// Serial clock generator: CLK_DIV-cycle half periods while enabled, parked high otherwise.
// The ticks flag the clk_adc edge that closes the current half period.
module adc_sclk_gen
    import adc_spi_capture_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_adc,
    input  logic rst_adc,
    input  logic en,
    output logic sclk_o,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DIV_W = cnt_w(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             phase_end;

    // Down-counter parks at zero, so the first enabled edge drops sclk immediately.
    assign phase_end = (div_cnt == '0);
    assign rise_tick = phase_end && !sclk_o;
    assign fall_tick = phase_end && sclk_o;

    always_ff @(posedge clk_adc) begin
        if (rst_adc) begin
            sclk_o  <= 1'b1;
            div_cnt <= '0;
        end else if (!en) begin
            sclk_o  <= 1'b1;
            div_cnt <= '0;
        end else if (phase_end) begin
            sclk_o  <= ~sclk_o;
            div_cnt <= DIV_W'(CLK_DIV - 1);
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_capture.sv
// Serial ADC capture: frames chip-select/sclk and shifts NUM_CH data lines in lock-step.
// Every output is registered from the next state, so it lines up with the state it describes.
module adc_spi_capture
    import adc_spi_capture_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int CS_IDLE    = DEF_CS_IDLE
) (
    input  logic                     clk_adc,
    input  logic                     rst_adc,
    input  logic                     start_i,
    input  logic                     cont_i,
    input  logic [NUM_CH-1:0]        data_i,
    output logic                     cs_o,
    output logic                     sclk_o,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic [NUM_CH*((FRAME_BITS > DATA_W) ? (FRAME_BITS - DATA_W) : 1)-1:0] pad_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam int PAD_W   = FRAME_BITS - DATA_W;
    localparam int GAP_CYC = CS_IDLE * 2 * CLK_DIV;
    localparam int CNT_W   = cnt_w(GAP_CYC);
    localparam int BIT_W   = cnt_w(FRAME_BITS);

    adc_state_e       state, next_state;
    logic [CNT_W-1:0] cyc_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             sclk_en, rise_tick, fall_tick;

    always_comb begin
        // NOTE: default first, so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            ST_IDLE:     if (start_i || cont_i) next_state = ST_CS_SETUP;
            ST_CS_SETUP: if (cyc_cnt == CNT_W'(CLK_DIV - 1)) next_state = ST_SHIFT;
            ST_SHIFT:    if (fall_tick && bit_cnt == BIT_W'(FRAME_BITS - 1)) next_state = ST_LOAD;
            ST_LOAD:     next_state = ST_GAP;
            ST_GAP:      if (cyc_cnt == CNT_W'(GAP_CYC - 1))
                             next_state = cont_i ? ST_CS_SETUP : ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    assign sclk_en = (next_state == ST_SHIFT);

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk_adc   (clk_adc),
        .rst_adc   (rst_adc),
        .en        (sclk_en),
        .sclk_o    (sclk_o),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk_adc) begin
        if (rst_adc) begin
            state     <= ST_IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            cs_o      <= 1'b1;
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every register here sees the pre-edge values of its peers.
            state <= next_state;
            if (next_state == state && (state == ST_CS_SETUP || state == ST_GAP))
                cyc_cnt <= cyc_cnt + 1'b1;
            else
                cyc_cnt <= '0;
            // Advances at the end of each bit's high phase and stops on the last bit.
            if (state != ST_SHIFT)
                bit_cnt <= '0;
            else if (fall_tick && bit_cnt != BIT_W'(FRAME_BITS - 1))
                bit_cnt <= bit_cnt + 1'b1;
            cs_o      <= !(next_state == ST_CS_SETUP || next_state == ST_SHIFT);
            busy_o    <= (next_state != ST_IDLE);
            valid_o   <= (next_state == ST_LOAD);
            overrun_o <= start_i && busy_o;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [FRAME_BITS-1:0] shift_q;
        logic [FRAME_BITS-1:0] frame_q;

        always_ff @(posedge clk_adc) begin
            if (rst_adc) begin
                // NOTE: capture registers are reset too, so data_o reads zero rather than a stale sample.
                shift_q <= '0;
                frame_q <= '0;
            end else begin
                if (rise_tick)
                    shift_q <= {shift_q[FRAME_BITS-2:0], data_i[k]};
                if (next_state == ST_LOAD)
                    frame_q <= shift_q;
            end
        end

        assign data_o[k*DATA_W +: DATA_W] = frame_q[DATA_W-1:0];
        if (PAD_W > 0) begin : g_pad
            assign pad_o[k*PAD_W +: PAD_W] = frame_q[FRAME_BITS-1:DATA_W];
        end
    end

    if (PAD_W <= 0) begin : g_no_pad
        assign pad_o = '0;
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// Scoreboard bench for adc_spi_capture: default geometry plus a 1-channel, no-pad sweep instance.
module tb_adc_spi_capture;

    localparam int FRAME_BITS = 16;
    localparam int CLK_DIV    = 4;
    localparam int PERIOD     = 149;

    typedef struct {
        logic [23:0] data;
        logic [7:0]  pad;
        int          fall_cyc;
        int          valid_cyc;
    } exp_t;

    logic clk_adc = 1'b0;
    always #5 clk_adc = ~clk_adc;

    logic        rst_adc = 1'b1, start_i = 1'b0, cont_i = 1'b0;
    logic [1:0]  data_i = '0;
    logic        cs_o, sclk_o, valid_o, busy_o, overrun_o;
    logic [23:0] data_o;
    logic [7:0]  pad_o;

    logic        start_s = 1'b0, cont_s = 1'b0;
    logic [0:0]  data_s = '0;
    logic        cs_s, sclk_s, valid_s, busy_s, overrun_s;
    logic [11:0] data_o_s;
    logic [0:0]  pad_s;

    adc_spi_capture u_dut (
        .clk_adc(clk_adc), .rst_adc(rst_adc), .start_i(start_i), .cont_i(cont_i),
        .data_i(data_i), .cs_o(cs_o), .sclk_o(sclk_o), .data_o(data_o), .pad_o(pad_o),
        .valid_o(valid_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    adc_spi_capture #(
        .NUM_CH(1), .FRAME_BITS(12), .DATA_W(12), .CLK_DIV(1), .CS_IDLE(2)
    ) u_dut_sweep (
        .clk_adc(clk_adc), .rst_adc(rst_adc), .start_i(start_s), .cont_i(cont_s),
        .data_i(data_s), .cs_o(cs_s), .sclk_o(sclk_s), .data_o(data_o_s), .pad_o(pad_s),
        .valid_o(valid_s), .busy_o(busy_s), .overrun_o(overrun_s)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          t0    = 0;
    exp_t        exp_q[$];
    logic [31:0] tx_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic queue_frame(input logic [15:0] p0, input logic [15:0] p1, input int k);
        exp_t e;
        tx_q.push_back({p1, p0});
        e.data      = {p1[11:0], p0[11:0]};
        e.pad       = {p1[15:12], p0[15:12]};
        e.fall_cyc  = t0 + 1 + k * PERIOD;
        e.valid_cyc = t0 + 133 + k * PERIOD;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk_adc);
    endtask

    always @(posedge clk_adc) cyc <= cyc + 1;

    // ADC model for the default instance: next bit launched on each sclk fall.
    logic [31:0] cur_pat = '0;
    int          bit_i = 0;
    always @(negedge cs_o) begin
        bit_i = 0;
        if (tx_q.size() > 0) cur_pat = tx_q.pop_front();
    end
    always @(negedge sclk_o) begin
        if (!cs_o && bit_i < FRAME_BITS) begin
            data_i[0] = cur_pat[FRAME_BITS-1-bit_i];
            data_i[1] = cur_pat[2*FRAME_BITS-1-bit_i];
            bit_i++;
        end
    end

    logic [11:0] pat_s = 12'hB4D;
    int          bit_s = 0;
    always @(negedge cs_s) bit_s = 0;
    always @(negedge sclk_s) begin
        if (!cs_s && bit_s < 12) begin
            data_s[0] = pat_s[11-bit_s];
            bit_s++;
        end
    end

    // Frame monitor and scoreboard pop for the default instance.
    logic cs_prev = 1'b1, sclk_prev = 1'b1;
    int   cs_fall_cyc = 0, rise_cnt = 0, run_len = 0;
    always @(negedge clk_adc) begin
        if (cs_prev && !cs_o) begin
            cs_fall_cyc = cyc;
            rise_cnt    = 0;
            run_len     = 1;
            if (exp_q.size() > 0) check("cs_fall_cycle", cyc, exp_q[0].fall_cyc);
        end else if (!cs_o) begin
            if (sclk_o != sclk_prev) begin
                if (exp_q.size() > 0) check("sclk_phase_len", run_len, CLK_DIV);
                if (sclk_o) rise_cnt++;
                run_len = 1;
            end else begin
                run_len++;
            end
        end else if (!cs_prev && exp_q.size() > 0) begin
            check("cs_low_cycles", cyc - cs_fall_cyc, 132);
            check("sclk_rises", rise_cnt, FRAME_BITS);
            check("sclk_last_high", run_len, CLK_DIV);
        end
        if (cs_o && !sclk_o) check("sclk_idle_high", sclk_o, 1'b1);
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", valid_o, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("valid_cycle", cyc, e.valid_cyc);
                check("data_o", data_o, e.data);
                check("pad_o", pad_o, e.pad);
            end
        end
        cs_prev   = cs_o;
        sclk_prev = sclk_o;
    end

    initial begin
        repeat (3) @(negedge clk_adc);
        check("rst_cs", cs_o, 1'b1);
        check("rst_sclk", sclk_o, 1'b1);
        check("rst_valid", valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_overrun", overrun_o, 1'b0);
        check("rst_data", data_o, 24'h0);
        check("rst_pad", pad_o, 8'h0);
        rst_adc = 1'b0;
        repeat (2) @(negedge clk_adc);

        // Single shot.
        t0 = cyc;
        queue_frame(16'hA5C3, 16'h0FFF, 0);
        start_i = 1'b1;
        @(negedge clk_adc);
        start_i = 1'b0;
        wait_until(t0 + 149);
        check("single_busy_in_gap", busy_o, 1'b1);
        @(negedge clk_adc);
        check("single_idle_after_gap", busy_o, 1'b0);
        check("single_data_hold", data_o, 24'hFFF5C3);
        check("single_drain", exp_q.size(), 0);
        repeat (5) @(negedge clk_adc);

        // Continuous, three frames; cont_i dropped during the third.
        t0 = cyc;
        queue_frame(16'h8001, 16'h7FFE, 0);
        queue_frame(16'h3C3C, 16'hC3C3, 1);
        queue_frame(16'hDEAD, 16'hBEEF, 2);
        cont_i = 1'b1;
        wait_until(t0 + 350);
        cont_i = 1'b0;
        wait_until(t0 + 447);
        check("cont_busy_in_gap", busy_o, 1'b1);
        @(negedge clk_adc);
        check("cont_idle_after_gap", busy_o, 1'b0);
        check("cont_drain", exp_q.size(), 0);
        repeat (5) @(negedge clk_adc);

        // Overrun: start request mid-frame is flagged for one cycle and dropped.
        t0 = cyc;
        queue_frame(16'h1234, 16'hFEDC, 0);
        start_i = 1'b1;
        @(negedge clk_adc);
        start_i = 1'b0;
        wait_until(t0 + 50);
        check("ovr_before", overrun_o, 1'b0);
        start_i = 1'b1;
        @(negedge clk_adc);
        start_i = 1'b0;
        check("ovr_pulse", overrun_o, 1'b1);
        @(negedge clk_adc);
        check("ovr_after", overrun_o, 1'b0);
        wait_until(t0 + 150);
        check("ovr_idle_after_gap", busy_o, 1'b0);
        wait_until(t0 + 180);
        check("ovr_no_extra_frame", busy_o, 1'b0);
        check("ovr_drain", exp_q.size(), 0);

        // Reset mid-SHIFT aborts the frame with no valid_o.
        t0 = cyc;
        tx_q.push_back(32'hFFFF_FFFF);
        start_i = 1'b1;
        @(negedge clk_adc);
        start_i = 1'b0;
        wait_until(t0 + 70);
        check("abort_busy_before", busy_o, 1'b1);
        rst_adc = 1'b1;
        @(negedge clk_adc);
        rst_adc = 1'b0;
        check("abort_cs", cs_o, 1'b1);
        check("abort_sclk", sclk_o, 1'b1);
        check("abort_data", data_o, 24'h0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_valid", valid_o, 1'b0);
        repeat (200) @(negedge clk_adc);
        check("abort_still_idle", busy_o, 1'b0);
        check("abort_drain", exp_q.size(), 0);

        // Parameter sweep instance: one channel, no pad bits, CLK_DIV=1.
        t0 = cyc;
        start_s = 1'b1;
        @(negedge clk_adc);
        start_s = 1'b0;
        for (int i = 0; i < 60 && !valid_s; i++) @(negedge clk_adc);
        check("sweep_latency", cyc - t0, 26);
        check("sweep_data", data_o_s, 12'hB4D);
        check("sweep_pad", pad_s, 1'b0);
        repeat (30) @(negedge clk_adc);
        check("sweep_idle", busy_s, 1'b0);
        check("sweep_no_overrun", overrun_s, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
